// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_if
//  Purpose  : Byte-stream handshake (rx_*) and program-RAM write port (wr_*)
//             carried between the stream source / RAM and the program loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Environment side: sources the stream and sinks the RAM writes.
    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    // Loader side: consumes the stream and drives the RAM write port.
    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Parses a SYNC/LEN/data/CSUM byte frame, writes the data bytes
//             into program RAM from address 0 and releases the CPU core from
//             reset only once a frame with a matching checksum is stored.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
    input  wire logic     clk,
    input  wire logic     reset,
    prog_loader_if.slave  bus,
    input  wire logic     restart,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);

    localparam int                CAP       = 1 << ADDR_W;
    // Largest legal LEN value, expressed in the stream byte width.
    localparam logic [DATA_W-1:0] c_cap_len = DATA_W'(CAP);
    // LEN == 0 encodes a full-memory load.
    localparam logic [ADDR_W:0]   c_cap_cnt = (ADDR_W + 1)'(CAP);
    localparam logic [ADDR_W:0]   c_one     = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_count;     // number of data bytes in the frame
    logic [ADDR_W:0]   r_idx;       // next RAM index to write
    logic [DATA_W-1:0] r_sum;       // running mod-2**DATA_W data sum
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_ready;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic [ADDR_W:0]   w_idx_next;

    assign w_accept   = bus.rx_valid && r_ready;
    assign w_idx_next = r_idx + c_one;

    assign bus.rx_ready = r_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign err          = r_err;

    // Frame parser: one transition per accepted byte, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_ready     <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Anything other than the sync marker is silently dropped.
                    if (w_accept && (bus.rx_data == SYNC_BYTE)) begin
                        r_state   <= S_LEN;
                        r_err     <= 1'b0;
                        r_sum     <= '0;
                        r_idx     <= '0;
                        r_wr_addr <= '0;
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        if (bus.rx_data > c_cap_len) begin
                            r_state     <= S_ERROR;
                            r_err       <= 1'b1;
                            r_cpu_reset <= 1'b1;
                            r_ready     <= 1'b0;
                        end else begin
                            r_count <= (bus.rx_data == '0) ? c_cap_cnt
                                                           : bus.rx_data[ADDR_W:0];
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_idx[ADDR_W-1:0];
                        r_wr_data <= bus.rx_data;
                        r_sum     <= r_sum + bus.rx_data;
                        r_idx     <= w_idx_next;
                        if (w_idx_next == r_count) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (bus.rx_data == r_sum) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state     <= S_ERROR;
                            r_err       <= 1'b1;
                            r_cpu_reset <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Core runs until a reload is requested.
                    if (restart) begin
                        r_state     <= S_IDLE;
                        r_done      <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_ready     <= 1'b1;
                    end
                end
                S_ERROR: begin
                    // One dead cycle, then hunt for the next sync marker; err stays set.
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader: frame-level reference
//             model compared every cycle plus literal RAM/flag expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic clk = 1'b0;
    logic reset;
    logic restart;
    logic cpu_reset;
    logic done;
    logic err;

    prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    prog_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .restart   (restart),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM image as actually written by the DUT.
    logic [7:0] ram [16];
    always @(posedge clk) begin
        if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    end

    // ---------------- Frame-level reference model ----------------
    localparam int P_HUNT = 0, P_LEN = 1, P_DATA = 2, P_SUM = 3, P_LOADED = 4, P_FAULT = 5;
    int         phase;
    int         want;
    byte unsigned q[$];
    logic [7:0] mram [16];
    bit         m_written [16];
    logic       m_wr_en, m_cpu_reset, m_done, m_err;
    logic [3:0] m_wr_addr;
    logic [7:0] m_wr_data;
    bit         m_acc;

    always @(posedge clk) begin
        int total;
        m_acc = 1'b0;
        if (reset) begin
            phase = P_HUNT;
            q.delete();
            m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
            m_cpu_reset = 1'b1; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_wr_en = 1'b0;
            m_acc = bus.rx_valid && (phase <= P_SUM);
            if (phase == P_FAULT) begin
                phase = P_HUNT;
            end else if (phase == P_LOADED) begin
                if (restart) begin
                    phase = P_HUNT; m_cpu_reset = 1'b1; m_done = 1'b0;
                end
            end else if (m_acc) begin
                case (phase)
                    P_HUNT: if (bus.rx_data == 8'hA5) begin
                        phase = P_LEN; m_err = 1'b0; q.delete(); m_wr_addr = '0;
                    end
                    P_LEN: begin
                        want = (bus.rx_data == 0) ? 16 : int'(bus.rx_data);
                        if (want > 16) begin phase = P_FAULT; m_err = 1'b1; end
                        else phase = P_DATA;
                    end
                    P_DATA: begin
                        m_wr_en = 1'b1;
                        m_wr_addr = 4'(q.size());
                        m_wr_data = bus.rx_data;
                        mram[q.size()] = bus.rx_data;
                        m_written[q.size()] = 1'b1;
                        q.push_back(bus.rx_data);
                        if (q.size() == want) phase = P_SUM;
                    end
                    default: begin
                        total = 0;
                        foreach (q[i]) total += int'(q[i]);
                        if (bus.rx_data == 8'(total)) begin
                            phase = P_LOADED; m_done = 1'b1; m_cpu_reset = 1'b0;
                        end else begin
                            phase = P_FAULT; m_err = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("rx_ready", bus.rx_ready, (phase <= P_SUM));
            check("wr_en", bus.wr_en, m_wr_en);
            check("cpu_reset", cpu_reset, m_cpu_reset);
            check("done", done, m_done);
            check("err", err, m_err);
            if (m_wr_en) begin
                check("wr_addr", bus.wr_addr, m_wr_addr);
                check("wr_data", bus.wr_data, m_wr_data);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int k = 0; k < 8 && !ok; k++) begin
            @(posedge clk); #1;
            ok = m_acc;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_accept: byte %02h not accepted within 8 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; restart = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 4'h0);
        check("rst_wr_data", bus.wr_data, 8'h00);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", bus.rx_ready, 1'b1);
        reset = 1'b0;
        idle(2);

        // 1: good 4-byte frame; 0x86+0x45+0x21+0xFF = 0x1EB -> checksum 0xEB
        send(8'hA5); send(8'h04);
        send(8'h86); send(8'h45); send(8'h21); send(8'hFF);
        send(8'hEB);
        check("t1_done", done, 1'b1);
        check("t1_cpu_reset", cpu_reset, 1'b0);
        check("t1_err", err, 1'b0);
        check("t1_ready", bus.rx_ready, 1'b0);
        check("t1_ram0", ram[0], 8'h86);
        check("t1_ram1", ram[1], 8'h45);
        check("t1_ram2", ram[2], 8'h21);
        check("t1_ram3", ram[3], 8'hFF);
        // byte offered while loaded must not be taken
        bus.rx_valid = 1'b1; bus.rx_data = 8'hA5;
        repeat (2) begin @(posedge clk); #1; end
        check("t1_hold_done", done, 1'b1);
        idle(1);

        // 2: same frame, wrong checksum
        pulse_restart();
        check("t2_restart_cpu_reset", cpu_reset, 1'b1);
        check("t2_restart_done", done, 1'b0);
        send(8'hA5); send(8'h04);
        send(8'h86); send(8'h45); send(8'h21); send(8'hFF);
        send(8'hF0);
        check("t2_err", err, 1'b1);
        check("t2_ready_low", bus.rx_ready, 1'b0);
        check("t2_done", done, 1'b0);
        idle(1);
        check("t2_back_idle_ready", bus.rx_ready, 1'b1);
        check("t2_err_sticky", err, 1'b1);
        check("t2_cpu_reset", cpu_reset, 1'b1);
        pulse_restart();   // ignored outside DONE
        check("t2_restart_ignored_done", done, 1'b0);

        // 3: garbage, then LEN=0 full-memory frame; bytes 10..1F sum to 0x178 -> 0x78
        send(8'h00); send(8'h13);
        send(8'hA5); send(8'h00);
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        send(8'h78);
        check("t3_done", done, 1'b1);
        check("t3_err_cleared", err, 1'b0);
        check("t3_ram0", ram[0], 8'h10);
        check("t3_ram15", ram[15], 8'h1F);
        idle(1);
        pulse_restart();

        // 4: LEN=0x11 is too long, then a good frame 55 66 (sum BB)
        send(8'hA5); send(8'h11);
        check("t4_err", err, 1'b1);
        check("t4_no_write", bus.wr_en, 1'b0);
        send(8'hA5); send(8'h02); send(8'h55); send(8'h66); send(8'hBB);
        check("t4_done", done, 1'b1);
        check("t4_err_cleared", err, 1'b0);
        check("t4_ram0", ram[0], 8'h55);
        check("t4_ram1", ram[1], 8'h66);
        idle(1);
        pulse_restart();

        // 5: reset mid-frame after two data bytes, then a fresh frame 33 44 (sum 77)
        send(8'hA5); send(8'h03); send(8'hAA); send(8'hBB);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_rst_wr_addr", bus.wr_addr, 4'h0);
        check("t5_rst_ready", bus.rx_ready, 1'b1);
        check("t5_rst_cpu_reset", cpu_reset, 1'b1);
        send(8'hA5); send(8'h02); send(8'h33); send(8'h44); send(8'h77);
        check("t5_done", done, 1'b1);
        check("t5_ram0", ram[0], 8'h33);
        check("t5_ram1", ram[1], 8'h44);
        idle(1);

        // 6: reload a single-byte program from DONE
        pulse_restart();
        send(8'hA5);
        check("t6_cpu_reset_loading", cpu_reset, 1'b1);
        send(8'h01); send(8'h0E); send(8'h0E);
        check("t6_done", done, 1'b1);
        check("t6_cpu_reset", cpu_reset, 1'b0);
        check("t6_ram0", ram[0], 8'h0E);
        idle(2);

        for (int i = 0; i < 16; i++) begin
            if (m_written[i]) check("ram_image", ram[i], mram[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
